// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding, R/W bit values, default
// PCF8574 address and datapath widths used by the I2C responder models.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_ADDR_ACK = 3'd2,
        ST_WR_DATA  = 3'd3,
        ST_WR_ACK   = 3'd4,
        ST_RD_DATA  = 3'd5,
        ST_RD_ACK   = 3'd6,
        ST_IGNORE   = 3'd7
    } i2c_state_e;

    localparam logic I2C_RW_WRITE = 1'b0;
    localparam logic I2C_RW_READ  = 1'b1;

    localparam logic [6:0] PCF8574_DEFAULT_ADDR = 7'h27;

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned BIT_CNT_W = 4;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchroniser with edge and START/STOP detection.
// Ports:
//   clk, reset_p          system clock, async active-high reset
//   scl, sda              raw asynchronous bus lines
//   scl_rise, scl_fall    1-clk pulses on synchronised SCL edges
//   start_det, stop_det   1-clk pulses: SDA fall / rise while SCL high
//   sda_s                 synchronised SDA, aligned with the pulses above
module i2c_bus_sync
    import i2c_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_p,
    input  logic scl,
    input  logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    // [SYNC_STAGES-1] is the synchronised copy, [SYNC_STAGES] is one clk older
    logic [SYNC_STAGES:0] scl_q;
    logic [SYNC_STAGES:0] sda_q;

    logic scl_now, scl_old, sda_now, sda_old;

    assign scl_now = scl_q[SYNC_STAGES-1];
    assign scl_old = scl_q[SYNC_STAGES];
    assign sda_now = sda_q[SYNC_STAGES-1];
    assign sda_old = sda_q[SYNC_STAGES];

    // Idle bus is high, so the chains reset to 1 to avoid phantom edges
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            scl_q     <= '1;
            sda_q     <= '1;
            scl_rise  <= 1'b0;
            scl_fall  <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
            sda_s     <= 1'b1;
        end else begin
            scl_q     <= {scl_q[SYNC_STAGES-1:0], scl};
            sda_q     <= {sda_q[SYNC_STAGES-1:0], sda};
            scl_rise  <= scl_now & ~scl_old;
            scl_fall  <= ~scl_now & scl_old;
            start_det <= scl_now & scl_old & sda_old & ~sda_now;
            stop_det  <= scl_now & scl_old & ~sda_old & sda_now;
            sda_s     <= sda_now;
        end
    end

endmodule

// File: rtl/i2c_target_pcf8574.sv
// PCF8574-style I2C target: 7-bit address match, write bytes latched onto
// o_port, reads return i_port. No clock stretching, no general call.
// Ports:
//   clk, reset_p   system clock (>= 20x SCL), async active-high reset
//   i_scl, i_sda   asynchronous bus inputs
//   o_sda_low      1 = pull SDA low (pad open-drain)
//   i_port         parallel input returned on reads
//   o_port         last complete byte written
//   o_wr_valid     1-clk pulse when o_port updates
//   o_rd_strobe    1-clk pulse when i_port is sampled for transmit
//   o_busy         high from an address-matched START until STOP or NACK
module i2c_target_pcf8574
    import i2c_pkg::*;
#(
    parameter logic [6:0]  ADDR        = PCF8574_DEFAULT_ADDR,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset_p,
    input  logic              i_scl,
    input  logic              i_sda,
    output logic              o_sda_low,
    input  logic [BYTE_W-1:0] i_port,
    output logic [BYTE_W-1:0] o_port,
    output logic              o_wr_valid,
    output logic              o_rd_strobe,
    output logic              o_busy
);

    logic scl_rise, scl_fall, start_det, stop_det, sda_s;

    i2c_bus_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_bus_sync (
        .clk       (clk),
        .reset_p   (reset_p),
        .scl       (i_scl),
        .sda       (i_sda),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_s     (sda_s)
    );

    i2c_state_e           state_q, state_d;
    logic [BIT_CNT_W-1:0] cnt_q, cnt_d;
    logic [BYTE_W-1:0]    shreg_q, shreg_d;
    logic                 rw_q, rw_d;
    logic                 tx_pend_q, tx_pend_d;
    logic                 sda_low_d, wr_valid_d, rd_strobe_d, busy_d;
    logic [BYTE_W-1:0]    port_d;

    logic [BYTE_W-1:0] shift_in;
    logic              last_bit;
    logic              addr_match;

    assign shift_in   = {shreg_q[BYTE_W-2:0], sda_s};
    assign last_bit   = (cnt_q == BIT_CNT_W'(7));
    assign addr_match = (shift_in[BYTE_W-1:1] == ADDR);

    // State register
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Next state; START/STOP override any bit-level progress
    always_comb begin
        state_d = state_q;
        if (stop_det) begin
            state_d = ST_IDLE;
        end else if (start_det) begin
            state_d = ST_ADDR;
        end else begin
            case (state_q)
                ST_ADDR:     if (scl_rise && last_bit)
                                 state_d = addr_match ? ST_ADDR_ACK : ST_IGNORE;
                ST_ADDR_ACK: if (scl_fall && o_sda_low)
                                 state_d = (rw_q == I2C_RW_READ) ? ST_RD_DATA : ST_WR_DATA;
                ST_WR_DATA:  if (scl_rise && last_bit) state_d = ST_WR_ACK;
                ST_WR_ACK:   if (scl_fall && o_sda_low) state_d = ST_WR_DATA;
                ST_RD_DATA:  if (scl_fall && !tx_pend_q && last_bit) state_d = ST_RD_ACK;
                ST_RD_ACK:   if (scl_rise) state_d = sda_s ? ST_IGNORE : ST_RD_DATA;
                default:     state_d = state_q;
            endcase
        end
    end

    // Next values of datapath and outputs
    always_comb begin
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        rw_d        = rw_q;
        tx_pend_d   = tx_pend_q;
        sda_low_d   = o_sda_low;
        port_d      = o_port;
        wr_valid_d  = 1'b0;
        rd_strobe_d = 1'b0;
        busy_d      = o_busy;
        if (stop_det) begin
            cnt_d     = '0;
            tx_pend_d = 1'b0;
            sda_low_d = 1'b0;
            busy_d    = 1'b0;
        end else if (start_det) begin
            cnt_d     = '0;
            tx_pend_d = 1'b0;
            sda_low_d = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR, ST_WR_DATA: if (scl_rise) begin
                    shreg_d = shift_in;
                    cnt_d   = cnt_q + BIT_CNT_W'(1);
                    if (last_bit) begin
                        cnt_d = '0;
                        if (state_q == ST_ADDR) begin
                            busy_d = addr_match;
                            if (addr_match) rw_d = shift_in[0];
                        end else begin
                            port_d     = shift_in;
                            wr_valid_d = 1'b1;
                        end
                    end
                end
                // First fall drives ACK, second fall releases it
                ST_ADDR_ACK, ST_WR_ACK: if (scl_fall) begin
                    if (!o_sda_low) begin
                        sda_low_d = 1'b1;
                    end else if (state_q == ST_ADDR_ACK && rw_q == I2C_RW_READ) begin
                        shreg_d     = i_port;
                        rd_strobe_d = 1'b1;
                        sda_low_d   = ~i_port[BYTE_W-1];
                    end else begin
                        sda_low_d = 1'b0;
                    end
                end
                // shreg[7] is the bit on the wire; tx_pend means bit7 not yet driven
                ST_RD_DATA: if (scl_fall) begin
                    if (tx_pend_q) begin
                        tx_pend_d = 1'b0;
                        sda_low_d = ~shreg_q[BYTE_W-1];
                    end else if (last_bit) begin
                        cnt_d     = '0;
                        sda_low_d = 1'b0;
                    end else begin
                        sda_low_d = ~shreg_q[BYTE_W-2];
                        shreg_d   = {shreg_q[BYTE_W-2:0], 1'b0};
                        cnt_d     = cnt_q + BIT_CNT_W'(1);
                    end
                end
                ST_RD_ACK: if (scl_rise) begin
                    if (sda_s) begin
                        busy_d = 1'b0;
                    end else begin
                        shreg_d     = i_port;
                        rd_strobe_d = 1'b1;
                        tx_pend_d   = 1'b1;
                    end
                end
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            cnt_q       <= '0;
            shreg_q     <= '0;
            rw_q        <= I2C_RW_WRITE;
            tx_pend_q   <= 1'b0;
            o_sda_low   <= 1'b0;
            o_port      <= 8'hFF;
            o_wr_valid  <= 1'b0;
            o_rd_strobe <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            rw_q        <= rw_d;
            tx_pend_q   <= tx_pend_d;
            o_sda_low   <= sda_low_d;
            o_port      <= port_d;
            o_wr_valid  <= wr_valid_d;
            o_rd_strobe <= rd_strobe_d;
            o_busy      <= busy_d;
        end
    end

endmodule

// File: tb/tb_i2c_target_pcf8574.sv
// Bench for i2c_target_pcf8574: bit-banged I2C master, vector table,
// directed corner sequences and randomized transfers against a
// transaction-level model.
module tb_i2c_target_pcf8574;

    localparam int unsigned Q  = 6;  // clk cycles per SCL quarter period
    localparam int unsigned NV = 7;

    logic       clk = 1'b0;
    logic       reset_p;
    logic       m_scl, m_sda;
    logic [7:0] i_port;
    logic       o_sda_low;
    logic [7:0] o_port;
    logic       o_wr_valid, o_rd_strobe, o_busy;
    wire        sda_bus = m_sda & ~o_sda_low;

    int n_cmp = 0;
    int n_err = 0;
    int wr_cnt = 0, rd_cnt = 0, busy_cnt = 0, low_cnt = 0;

    always #5 clk = ~clk;

    i2c_target_pcf8574 #(.ADDR(7'h27), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .reset_p     (reset_p),
        .i_scl       (m_scl),
        .i_sda       (sda_bus),
        .o_sda_low   (o_sda_low),
        .i_port      (i_port),
        .o_port      (o_port),
        .o_wr_valid  (o_wr_valid),
        .o_rd_strobe (o_rd_strobe),
        .o_busy      (o_busy)
    );

    always @(negedge clk) begin
        if (o_wr_valid)  wr_cnt++;
        if (o_rd_strobe) rd_cnt++;
        if (o_busy)      busy_cnt++;
        if (o_sda_low)   low_cnt++;
    end

    initial begin
        #(900_000);
        $display("FAIL watchdog: got no completion, required finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic quarter();
        repeat (Q) @(posedge clk);
    endtask

    task automatic start_cond();
        m_sda = 1'b1; quarter();
        m_scl = 1'b1; quarter();
        m_sda = 1'b0; quarter();
        m_scl = 1'b0; quarter();
    endtask

    task automatic stop_cond();
        m_sda = 1'b0; quarter();
        m_scl = 1'b1; quarter();
        m_sda = 1'b1; quarter();
    endtask

    task automatic clock_bit(input logic b, output logic s);
        m_sda = b; quarter();
        m_scl = 1'b1;
        repeat (Q/2) @(posedge clk);
        @(negedge clk) s = sda_bus;
        repeat (Q/2) @(posedge clk);
        m_scl = 1'b0; quarter();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic acked);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
        clock_bit(1'b1, s);
        acked = ~s;
    endtask

    task automatic read_bits(output logic [7:0] d);
        logic s;
        logic [7:0] t;
        t = '0;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, s);
            t[i] = s;
        end
        d = t;
    endtask

    typedef struct {
        logic       rw;
        logic [6:0] addr;
        logic [7:0] data;
        logic       exp_ack;
        logic [7:0] exp_port;
        logic [7:0] exp_rd;
        int         exp_wr;
        int         exp_rs;
    } vec_t;

    vec_t vecs [NV];

    initial begin
        logic       acked, s;
        logic [7:0] rd, mdl_port, b4e;
        logic [6:0] addr;
        logic       rw, match;
        logic [7:0] data [3];
        int         nb, wr0, rd0, bz0, lo0;

        vecs[0] = '{1'b0, 7'h20, 8'h12, 1'b0, 8'hFF, 8'hFF, 0, 0};
        vecs[1] = '{1'b0, 7'h27, 8'hA5, 1'b1, 8'hA5, 8'hFF, 1, 0};
        vecs[2] = '{1'b1, 7'h27, 8'h3C, 1'b1, 8'hA5, 8'h3C, 0, 1};
        vecs[3] = '{1'b0, 7'h00, 8'h55, 1'b0, 8'hA5, 8'hFF, 0, 0};
        vecs[4] = '{1'b1, 7'h26, 8'h99, 1'b0, 8'hA5, 8'hFF, 0, 0};
        vecs[5] = '{1'b0, 7'h27, 8'h00, 1'b1, 8'h00, 8'hFF, 1, 0};
        vecs[6] = '{1'b1, 7'h27, 8'hC3, 1'b1, 8'h00, 8'hC3, 0, 1};

        reset_p = 1'b1; m_scl = 1'b1; m_sda = 1'b1; i_port = 8'h00;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("reset_port", o_port, 8'hFF);
        check("reset_sda_low", o_sda_low, 1'b0);
        check("reset_busy", o_busy, 1'b0);
        check("reset_wr_valid", o_wr_valid, 1'b0);
        check("reset_rd_strobe", o_rd_strobe, 1'b0);
        reset_p = 1'b0;
        quarter();

        // Vector table
        for (int k = 0; k < NV; k++) begin
            wr0 = wr_cnt; rd0 = rd_cnt; bz0 = busy_cnt; lo0 = low_cnt;
            i_port = vecs[k].data;
            start_cond();
            write_byte({vecs[k].addr, vecs[k].rw}, acked);
            check($sformatf("vec%0d_addr_ack", k), acked, vecs[k].exp_ack);
            if (vecs[k].rw == 1'b0) begin
                write_byte(vecs[k].data, acked);
                check($sformatf("vec%0d_data_ack", k), acked, vecs[k].exp_ack);
            end else begin
                read_bits(rd);
                clock_bit(1'b1, s);
                check($sformatf("vec%0d_rd_data", k), rd, vecs[k].exp_rd);
            end
            stop_cond(); quarter();
            check($sformatf("vec%0d_port", k), o_port, vecs[k].exp_port);
            check($sformatf("vec%0d_wr_pulses", k), wr_cnt - wr0, vecs[k].exp_wr);
            check($sformatf("vec%0d_rd_strobes", k), rd_cnt - rd0, vecs[k].exp_rs);
            check($sformatf("vec%0d_busy_seen", k), (busy_cnt - bz0) != 0, vecs[k].exp_ack);
            check($sformatf("vec%0d_sda_pulled", k), (low_cnt - lo0) != 0, vecs[k].exp_ack);
            check($sformatf("vec%0d_busy_after_stop", k), o_busy, 1'b0);
        end

        // Multi-byte read with i_port changing between bytes
        rd0 = rd_cnt;
        i_port = 8'h01;
        start_cond();
        write_byte(8'h4F, acked);
        check("mrd_addr_ack", acked, 1'b1);
        read_bits(rd);
        check("mrd_byte0", rd, 8'h01);
        i_port = 8'h02;
        clock_bit(1'b0, s);
        read_bits(rd);
        check("mrd_byte1", rd, 8'h02);
        clock_bit(1'b1, s);
        @(negedge clk);
        check("mrd_busy_after_nack", o_busy, 1'b0);
        check("mrd_released_after_nack", o_sda_low, 1'b0);
        stop_cond(); quarter();
        check("mrd_strobes", rd_cnt - rd0, 2);

        // Repeated START mid-byte discards the partial write
        wr0 = wr_cnt; rd0 = rd_cnt;
        i_port = 8'h5A;
        start_cond();
        write_byte(8'h4E, acked);
        check("rs_addr_w_ack", acked, 1'b1);
        clock_bit(1'b1, s); clock_bit(1'b0, s); clock_bit(1'b1, s); clock_bit(1'b0, s);
        start_cond();
        write_byte(8'h4F, acked);
        check("rs_addr_r_ack", acked, 1'b1);
        read_bits(rd);
        clock_bit(1'b1, s);
        stop_cond(); quarter();
        check("rs_rd_data", rd, 8'h5A);
        check("rs_port_unchanged", o_port, 8'h00);
        check("rs_no_wr", wr_cnt - wr0, 0);
        check("rs_rd_strobes", rd_cnt - rd0, 1);

        // Async reset while the target drives the address ACK
        b4e = 8'h4E;
        start_cond();
        for (int i = 7; i >= 0; i--) clock_bit(b4e[i], s);
        m_sda = 1'b1; quarter();
        m_scl = 1'b1; quarter();
        @(negedge clk);
        check("rst_ack_driven", o_sda_low, 1'b1);
        reset_p = 1'b1;
        #1;
        check("rst_sda_immediate", o_sda_low, 1'b0);
        check("rst_port", o_port, 8'hFF);
        check("rst_busy", o_busy, 1'b0);
        m_scl = 1'b0; quarter();
        reset_p = 1'b0; quarter();
        stop_cond(); quarter();
        wr0 = wr_cnt;
        start_cond();
        write_byte(8'h4E, acked);
        check("rst_after_addr_ack", acked, 1'b1);
        write_byte(8'h77, acked);
        check("rst_after_data_ack", acked, 1'b1);
        stop_cond(); quarter();
        check("rst_after_port", o_port, 8'h77);
        check("rst_after_wr", wr_cnt - wr0, 1);

        // Randomized transfers against a transaction-level model
        mdl_port = 8'h77;
        for (int t = 0; t < 24; t++) begin
            addr  = ($urandom_range(0, 3) != 0) ? 7'h27 : 7'($urandom_range(0, 127));
            rw    = 1'($urandom_range(0, 1));
            nb    = $urandom_range(1, 3);
            match = (addr == 7'h27);
            for (int b = 0; b < 3; b++) data[b] = 8'($urandom);
            wr0 = wr_cnt; rd0 = rd_cnt;
            i_port = data[0];
            start_cond();
            write_byte({addr, rw}, acked);
            check($sformatf("rnd%0d_addr_ack", t), acked, match);
            for (int b = 0; b < nb; b++) begin
                if (!rw) begin
                    write_byte(data[b], acked);
                    check($sformatf("rnd%0d_wack%0d", t, b), acked, match);
                    if (match) mdl_port = data[b];
                end else begin
                    read_bits(rd);
                    if (b < nb - 1) begin
                        i_port = data[b+1];
                        clock_bit(1'b0, s);
                    end else begin
                        clock_bit(1'b1, s);
                    end
                    check($sformatf("rnd%0d_rd%0d", t, b), rd, match ? data[b] : 8'hFF);
                end
            end
            stop_cond(); quarter();
            check($sformatf("rnd%0d_port", t), o_port, mdl_port);
            check($sformatf("rnd%0d_wr", t), wr_cnt - wr0, (match && !rw) ? nb : 0);
            check($sformatf("rnd%0d_rs", t), rd_cnt - rd0, (match && rw) ? nb : 0);
            check($sformatf("rnd%0d_busy", t), o_busy, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
